// File: rtl/ddr_global_pkg.sv
// Shared types for the ddr_fifo side controllers.
// Holds the write-controller state encoding.
package ddr_global_pkg;

  typedef enum logic [1:0] {
    FWC_IDLE  = 2'd0,
    FWC_BURST = 2'd1,
    FWC_LOAD  = 2'd2
  } ddr_fwc_state_t;

endpackage

// File: rtl/ddr_rr_arb.sv
// Combinational round-robin arbiter: grants the first request at or after
// i_ptr, searching cyclically. One-hot output, zero when nothing requests.
module ddr_rr_arb #(
  parameter int N = 4
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_ptr,
  output logic [N-1:0]         o_gnt
);

  int   idx;
  logic found;

  always_comb begin
    o_gnt = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(i_ptr) + i) % N;
      if (!found && i_req[idx]) begin
        o_gnt[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ddr_fifo_wr_ctrl.sv
// Write-side controller for a synchronous ddr_fifo: round-robin burst
// arbitration onto the write port plus collision-free loop reconfiguration.
module ddr_fifo_wr_ctrl
  import ddr_global_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int WWIDTH = 32,
  parameter int AWIDTH = 3
) (
  input  logic                   i_wclk,
  input  logic                   wrst_scan,
  input  logic                   i_clr,
  input  logic [NREQ-1:0]        i_req_valid,
  input  logic [NREQ-1:0]        i_req_last,
  input  logic [NREQ*WWIDTH-1:0] i_req_data,
  output logic [NREQ-1:0]        o_req_ready,
  output logic [NREQ-1:0]        o_grant,
  output logic                   o_write,
  output logic [WWIDTH-1:0]      o_wdata,
  input  logic                   i_full,
  input  logic                   i_cfg_load,
  input  logic                   i_cfg_loop_mode,
  input  logic [AWIDTH-1:0]      i_cfg_start_ptr,
  input  logic [AWIDTH-1:0]      i_cfg_stop_ptr,
  output logic                   o_loop_mode,
  output logic [AWIDTH-1:0]      o_start_ptr,
  output logic [AWIDTH-1:0]      o_stop_ptr,
  output logic                   o_load_ptr,
  output logic                   o_cfg_ack,
  output logic                   o_busy
);

  localparam int IW = $clog2(NREQ);

  ddr_fwc_state_t    state;
  logic [IW-1:0]     rr_ptr;
  logic [IW-1:0]     owner;
  logic [IW-1:0]     win_idx;
  logic [IW-1:0]     cur_idx;
  logic [IW-1:0]     rr_next;
  logic [NREQ-1:0]   arb_gnt;
  logic              grant_en;
  logic              accept;
  logic              cur_last;
  logic [WWIDTH-1:0] cur_data;
  logic              cfg_pend;
  logic              shd_loop_mode;
  logic [AWIDTH-1:0] shd_start_ptr;
  logic [AWIDTH-1:0] shd_stop_ptr;

  ddr_rr_arb #(.N(NREQ)) u_arb (
    .i_req (i_req_valid),
    .i_ptr (rr_ptr),
    .o_gnt (arb_gnt)
  );

  always_comb begin
    win_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (arb_gnt[k]) win_idx = IW'(k);
    end
  end

  // A pending load freezes new grants in IDLE so the write pipe can drain.
  always_comb begin
    cur_idx  = win_idx;
    grant_en = 1'b0;
    case (state)
      FWC_IDLE: begin
        cur_idx  = win_idx;
        grant_en = !cfg_pend && (|arb_gnt);
      end
      FWC_BURST: begin
        cur_idx  = owner;
        grant_en = 1'b1;
      end
      default: begin
        cur_idx  = win_idx;
        grant_en = 1'b0;
      end
    endcase
  end

  assign o_grant     = grant_en ? (NREQ'(1) << cur_idx) : '0;
  assign o_req_ready = o_grant & {NREQ{~i_full & ~i_clr}};
  assign accept      = |(i_req_valid & o_req_ready);
  assign cur_last    = i_req_last[cur_idx];
  assign cur_data    = i_req_data[int'(cur_idx)*WWIDTH +: WWIDTH];
  assign rr_next     = (win_idx == IW'(NREQ-1)) ? '0 : win_idx + IW'(1);
  assign o_busy      = (state != FWC_IDLE) || cfg_pend || o_write;

  // Load only once o_write is low, since load_ptr would override a write.
  always_ff @(posedge i_wclk or posedge wrst_scan) begin
    if (wrst_scan) begin
      state         <= FWC_IDLE;
      rr_ptr        <= '0;
      owner         <= '0;
      cfg_pend      <= 1'b0;
      shd_loop_mode <= 1'b0;
      shd_start_ptr <= '0;
      shd_stop_ptr  <= '0;
      o_write       <= 1'b0;
      o_wdata       <= '0;
      o_loop_mode   <= 1'b0;
      o_start_ptr   <= '0;
      o_stop_ptr    <= '0;
      o_load_ptr    <= 1'b0;
      o_cfg_ack     <= 1'b0;
    end else if (i_clr) begin
      state      <= FWC_IDLE;
      rr_ptr     <= '0;
      cfg_pend   <= 1'b0;
      o_write    <= 1'b0;
      o_load_ptr <= 1'b0;
      o_cfg_ack  <= 1'b0;
    end else begin
      o_write    <= accept;
      o_load_ptr <= 1'b0;
      o_cfg_ack  <= 1'b0;
      if (accept) o_wdata <= cur_data;
      if (i_cfg_load) begin
        shd_loop_mode <= i_cfg_loop_mode;
        shd_start_ptr <= i_cfg_start_ptr;
        shd_stop_ptr  <= i_cfg_stop_ptr;
        cfg_pend      <= 1'b1;
      end
      case (state)
        FWC_IDLE: begin
          if (accept) begin
            rr_ptr <= rr_next;
            owner  <= win_idx;
            if (!cur_last) state <= FWC_BURST;
          end else if (cfg_pend && !o_write) begin
            state       <= FWC_LOAD;
            o_loop_mode <= shd_loop_mode;
            o_start_ptr <= shd_start_ptr;
            o_stop_ptr  <= shd_stop_ptr;
            o_load_ptr  <= 1'b1;
            o_cfg_ack   <= 1'b1;
            if (!i_cfg_load) cfg_pend <= 1'b0;
          end
        end
        FWC_BURST: begin
          if (accept && cur_last) state <= FWC_IDLE;
        end
        default: state <= FWC_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_fifo_wr_ctrl.sv
// Directed self-checking bench for ddr_fifo_wr_ctrl; expected FIFO writes
// are queued as beats are offered and popped when o_write fires.
module tb_ddr_fifo_wr_ctrl;

  localparam int NREQ   = 4;
  localparam int WWIDTH = 32;
  localparam int AWIDTH = 3;

  logic                   i_wclk = 1'b0;
  logic                   wrst_scan;
  logic                   i_clr;
  logic [NREQ-1:0]        i_req_valid;
  logic [NREQ-1:0]        i_req_last;
  logic [NREQ*WWIDTH-1:0] i_req_data;
  logic [NREQ-1:0]        o_req_ready;
  logic [NREQ-1:0]        o_grant;
  logic                   o_write;
  logic [WWIDTH-1:0]      o_wdata;
  logic                   i_full;
  logic                   i_cfg_load;
  logic                   i_cfg_loop_mode;
  logic [AWIDTH-1:0]      i_cfg_start_ptr;
  logic [AWIDTH-1:0]      i_cfg_stop_ptr;
  logic                   o_loop_mode;
  logic [AWIDTH-1:0]      o_start_ptr;
  logic [AWIDTH-1:0]      o_stop_ptr;
  logic                   o_load_ptr;
  logic                   o_cfg_ack;
  logic                   o_busy;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  ddr_fifo_wr_ctrl #(.NREQ(NREQ), .WWIDTH(WWIDTH), .AWIDTH(AWIDTH)) dut (
    .i_wclk          (i_wclk),
    .wrst_scan       (wrst_scan),
    .i_clr           (i_clr),
    .i_req_valid     (i_req_valid),
    .i_req_last      (i_req_last),
    .i_req_data      (i_req_data),
    .o_req_ready     (o_req_ready),
    .o_grant         (o_grant),
    .o_write         (o_write),
    .o_wdata         (o_wdata),
    .i_full          (i_full),
    .i_cfg_load      (i_cfg_load),
    .i_cfg_loop_mode (i_cfg_loop_mode),
    .i_cfg_start_ptr (i_cfg_start_ptr),
    .i_cfg_stop_ptr  (i_cfg_stop_ptr),
    .o_loop_mode     (o_loop_mode),
    .o_start_ptr     (o_start_ptr),
    .o_stop_ptr      (o_stop_ptr),
    .o_load_ptr      (o_load_ptr),
    .o_cfg_ack       (o_cfg_ack),
    .o_busy          (o_busy)
  );

  always #5 i_wclk = ~i_wclk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_wclk);
    #1;
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic [NREQ-1:0] last);
    i_req_valid = valid;
    i_req_last  = last;
    #1;
  endtask

  task automatic setData(input int k, input logic [31:0] d);
    i_req_data[k*WWIDTH +: WWIDTH] = d;
  endtask

  // Every FIFO write must match the oldest queued expectation.
  always @(negedge i_wclk) begin
    if (!wrst_scan && o_write === 1'b1) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_write", o_wdata, 32'hDEAD_DEAD);
      end else begin
        checkOutput("wdata", o_wdata, exp_q.pop_front());
      end
    end
  end

  initial begin
    wrst_scan       = 1'b1;
    i_clr           = 1'b0;
    i_req_valid     = '0;
    i_req_last      = '0;
    i_req_data      = '0;
    i_full          = 1'b0;
    i_cfg_load      = 1'b0;
    i_cfg_loop_mode = 1'b0;
    i_cfg_start_ptr = '0;
    i_cfg_stop_ptr  = '0;
    tick();
    tick();
    wrst_scan = 1'b0;
    #1;
    checkOutput("rst_grant", 32'(o_grant), 32'h0);
    checkOutput("rst_write", 32'(o_write), 32'h0);
    checkOutput("rst_busy", 32'(o_busy), 32'h0);
    checkOutput("rst_cfg", {o_loop_mode, o_start_ptr, o_stop_ptr, o_load_ptr, o_cfg_ack}, 32'h0);

    // Round robin of single-beat bursts, no bubbles.
    for (int k = 0; k < NREQ; k++) setData(k, 32'h10 + k);
    applyStimulus(4'b1111, 4'b1111);
    for (int i = 0; i < NREQ; i++) begin
      checkOutput($sformatf("rr_grant%0d", i), 32'(o_grant), 32'(1 << i));
      exp_q.push_back(32'h10 + i);
      tick();
      if (i == NREQ - 1) applyStimulus(4'b0000, 4'b0000);
      checkOutput($sformatf("rr_write%0d", i), 32'(o_write), 32'h1);
    end
    tick();
    checkOutput("rr_write_idle", 32'(o_write), 32'h0);

    // Req0 single beat moves the pointer to 1, then req1 bursts over req0.
    setData(0, 32'h20);
    applyStimulus(4'b0001, 4'b0001);
    exp_q.push_back(32'h20);
    tick();
    setData(0, 32'h21);
    setData(1, 32'h30);
    applyStimulus(4'b0011, 4'b0001);
    checkOutput("lock_grant0", 32'(o_grant), 32'h2);
    exp_q.push_back(32'h30);
    tick();
    applyStimulus(4'b0001, 4'b0001);
    checkOutput("lock_hold_grant", 32'(o_grant), 32'h2);
    checkOutput("lock_hold_ready0", 32'(o_req_ready[0]), 32'h0);
    tick();
    setData(1, 32'h31);
    applyStimulus(4'b0011, 4'b0001);
    checkOutput("lock_ready1", 32'(o_req_ready), 32'h2);
    exp_q.push_back(32'h31);
    tick();
    setData(1, 32'h32);
    applyStimulus(4'b0011, 4'b0011);
    checkOutput("lock_ready2", 32'(o_req_ready), 32'h2);
    exp_q.push_back(32'h32);
    tick();
    checkOutput("lock_after_grant", 32'(o_grant), 32'h1);
    exp_q.push_back(32'h21);
    tick();
    applyStimulus(4'b0000, 4'b0000);
    tick();

    // Full stall in the middle of a req2 burst.
    setData(2, 32'hA0);
    applyStimulus(4'b0100, 4'b0000);
    checkOutput("full_grant", 32'(o_grant), 32'h4);
    exp_q.push_back(32'hA0);
    tick();
    setData(2, 32'hA1);
    i_full = 1'b1;
    #1;
    checkOutput("full_ready", 32'(o_req_ready), 32'h0);
    tick();
    checkOutput("full_nowrite0", 32'(o_write), 32'h0);
    tick();
    checkOutput("full_nowrite1", 32'(o_write), 32'h0);
    i_full = 1'b0;
    #1;
    checkOutput("full_release_ready", 32'(o_req_ready), 32'h4);
    exp_q.push_back(32'hA1);
    tick();
    setData(2, 32'hA2);
    applyStimulus(4'b0100, 4'b0100);
    exp_q.push_back(32'hA2);
    tick();
    applyStimulus(4'b0000, 4'b0000);
    tick();

    // Config request arriving with the first beat of a req3 burst.
    setData(3, 32'hB0);
    i_cfg_load      = 1'b1;
    i_cfg_loop_mode = 1'b1;
    i_cfg_start_ptr = 3'd2;
    i_cfg_stop_ptr  = 3'd5;
    applyStimulus(4'b1000, 4'b0000);
    checkOutput("cfg_accept_grant", 32'(o_grant), 32'h8);
    exp_q.push_back(32'hB0);
    tick();
    i_cfg_load      = 1'b0;
    i_cfg_loop_mode = 1'b0;
    i_cfg_start_ptr = 3'd7;
    i_cfg_stop_ptr  = 3'd1;
    setData(3, 32'hB1);
    #1;
    checkOutput("cfg_busy", 32'(o_busy), 32'h1);
    exp_q.push_back(32'hB1);
    tick();
    setData(3, 32'hB2);
    applyStimulus(4'b1000, 4'b1000);
    exp_q.push_back(32'hB2);
    tick();
    applyStimulus(4'b0001, 4'b0001);
    checkOutput("cfg_wait_load0", 32'(o_load_ptr), 32'h0);
    checkOutput("cfg_wait_grant0", 32'(o_grant), 32'h0);
    tick();
    checkOutput("cfg_drain_write", 32'(o_write), 32'h0);
    checkOutput("cfg_wait_load1", 32'(o_load_ptr), 32'h0);
    checkOutput("cfg_wait_grant1", 32'(o_grant), 32'h0);
    tick();
    applyStimulus(4'b0000, 4'b0000);
    checkOutput("cfg_load_ptr", 32'(o_load_ptr), 32'h1);
    checkOutput("cfg_ack", 32'(o_cfg_ack), 32'h1);
    checkOutput("cfg_values", {o_loop_mode, o_start_ptr, o_stop_ptr}, {25'h0, 1'b1, 3'd2, 3'd5});
    tick();
    checkOutput("cfg_load_end", {o_load_ptr, o_cfg_ack}, 32'h0);
    checkOutput("cfg_busy_end", 32'(o_busy), 32'h0);

    // Soft clear mid-burst with a load pending, plus a dropped same-cycle load.
    setData(1, 32'hC0);
    applyStimulus(4'b0010, 4'b0000);
    checkOutput("clr_grant", 32'(o_grant), 32'h2);
    exp_q.push_back(32'hC0);
    tick();
    setData(1, 32'hC1);
    i_cfg_load      = 1'b1;
    i_cfg_loop_mode = 1'b0;
    i_cfg_start_ptr = 3'd6;
    i_cfg_stop_ptr  = 3'd1;
    exp_q.push_back(32'hC1);
    tick();
    i_clr      = 1'b1;
    i_cfg_load = 1'b1;
    #1;
    tick();
    i_clr      = 1'b0;
    i_cfg_load = 1'b0;
    applyStimulus(4'b0000, 4'b0000);
    checkOutput("clr_write", 32'(o_write), 32'h0);
    checkOutput("clr_busy", 32'(o_busy), 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput($sformatf("clr_no_ack%0d", i), {o_load_ptr, o_cfg_ack}, 32'h0);
    end
    checkOutput("clr_cfg_kept", {o_loop_mode, o_start_ptr, o_stop_ptr}, {25'h0, 1'b1, 3'd2, 3'd5});
    setData(0, 32'hD0);
    applyStimulus(4'b1111, 4'b1111);
    checkOutput("clr_rr_restart", 32'(o_grant), 32'h1);
    exp_q.push_back(32'hD0);
    tick();
    applyStimulus(4'b0000, 4'b0000);
    tick();
    tick();
    checkOutput("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ddr_fifo_wr_ctrl.md
Name: ddr_fifo_wr_ctrl

Overview:
- Write-side controller for a synchronous (SYNC=1) ddr_fifo instance.
- Shares the FIFO write port among NREQ requesters using round-robin arbitration, with burst locking and full backpressure.
- Sequences loop-mode reconfiguration: start/stop pointers, loop enable, and the load_ptr pulse, so a load never collides with an in-flight write.
- Sits between the requesters and the FIFO write/config pins in the same clock domain.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WWIDTH, 32, write data width; matches FIFO WWIDTH.
- AWIDTH, 3, FIFO pointer width; matches FIFO AWIDTH.

Ports:
- i_wclk  in  1  clock.
- wrst_scan  in  1  reset: asynchronous, active-high; clock i_wclk.
- i_clr  in  1  synchronous soft clear.
- i_req_valid  in  NREQ  per-requester beat valid.
- i_req_last  in  NREQ  final beat of the burst.
- i_req_data  in  NREQ*WWIDTH  per-requester data; requester k uses bits [k*WWIDTH +: WWIDTH].
- o_req_ready  out  NREQ  beat accepted when valid & ready.
- o_grant  out  NREQ  one-hot current owner; 0 when none.
- o_write  out  1  to FIFO i_write.
- o_wdata  out  WWIDTH  to FIFO i_wdata.
- i_full  in  1  from FIFO o_full.
- i_cfg_load  in  1  pulse requesting a reconfiguration.
- i_cfg_loop_mode  in  1  loop enable to apply.
- i_cfg_start_ptr  in  AWIDTH  start pointer to apply.
- i_cfg_stop_ptr  in  AWIDTH  stop pointer to apply.
- o_loop_mode  out  1  to FIFO i_loop_mode.
- o_start_ptr  out  AWIDTH  to FIFO i_start_ptr.
- o_stop_ptr  out  AWIDTH  to FIFO i_stop_ptr.
- o_load_ptr  out  1  to FIFO i_load_ptr.
- o_cfg_ack  out  1  one-cycle pulse when the load is applied.
- o_busy  out  1  high when the state is not IDLE, or a load is pending, or o_write=1.

Behaviour:
- Reset (wrst_scan): state IDLE, rr_ptr=0, cfg_pend=0. All outputs 0, including o_loop_mode, o_start_ptr, o_stop_ptr and the shadow config.
- States: IDLE, BURST, LOAD.
- Acceptance: accept = |(i_req_valid & o_req_ready). o_req_ready is one-hot and is only asserted to the owner when i_full=0.
- Data path: on accept, o_write<=1 and o_wdata<=owner data on the next edge; otherwise o_write<=0 and o_wdata holds its value. Latency is one cycle from accept to FIFO write.
- Backpressure: i_full already includes this cycle's o_write, so gating on i_full alone cannot overflow the FIFO.
- IDLE arbitration:
  - If cfg_pend=0, winner = first valid requester at or after rr_ptr, searching cyclically; o_grant=winner.
  - On accept: rr_ptr<=winner+1 mod NREQ. If the beat has last=0, go to BURST; if last=1, stay in IDLE.
  - Back-to-back single-beat bursts from different requesters have zero bubbles.
- BURST:
  - Owner is locked; other requesters get ready=0 even when valid.
  - Owner valid=0 holds the lock.
  - Accepted beat with last=1 returns to IDLE.
- Config request:
  - i_cfg_load captures the three cfg inputs into shadow registers and sets cfg_pend.
  - A repeat i_cfg_load while pending overwrites the shadow; only one ack results.
- Config application:
  - In IDLE with cfg_pend=1, o_grant=0 and no beat is accepted.
  - Transition to LOAD happens only when o_write=0 this cycle, so an in-flight write is never clobbered by load_ptr priority.
  - The IDLE->LOAD transition registers the shadow onto o_loop_mode/o_start_ptr/o_stop_ptr and asserts o_load_ptr.
- LOAD (exactly 1 cycle):
  - o_load_ptr=1, o_cfg_ack=1, cfg_pend cleared.
  - No grants; next state IDLE.
- Mid-burst config: a pending load waits for the burst's last beat and one drain cycle.
- i_clr:
  - Next edge: state IDLE, cfg_pend=0, rr_ptr=0, o_write=0, o_load_ptr=0.
  - Config outputs retain their values; i_clr has priority over all transitions.
  - An i_cfg_load in the same cycle as i_clr is dropped.
- Simultaneous i_cfg_load and an accept in IDLE: the accept completes, and the load applies once the pipeline drains.

Decomposition:
- ddr_global_pkg: typedef enum logic [1:0] ddr_fwc_state_t {FWC_IDLE, FWC_BURST, FWC_LOAD}.
- Sub-module ddr_rr_arb #(N): inputs i_req[N] and i_ptr[$clog2(N)]; output o_gnt[N], one-hot. Purely combinational masked priority encoder; reusable.

Test Plan:
- Reset, then check outputs -> all 0, o_busy=0; the first arbitration with valid=4'b1111 grants requester 0.
- Four requesters each hold a 1-beat burst for 4 cycles -> o_grant sequence 0001, 0010, 0100, 1000; o_write=1 for 4 consecutive cycles, one cycle after the accepts.
- Req1 sends a 3-beat burst while req0 stays valid -> req0 ready=0 until req1's last beat; then req0 is granted.
- Force i_full=1 for 2 cycles mid-burst -> ready=0, no o_write during the stall beats; data order is preserved (0xA0, 0xA1, 0xA2).
- i_cfg_load (loop=1, start=2, stop=5) during a burst -> the load waits; o_load_ptr pulses exactly once after the last write plus one idle cycle; o_start_ptr=2, o_stop_ptr=5, o_loop_mode=1; o_cfg_ack=1 in the same cycle.
- i_clr asserted mid-burst with a load pending -> next cycle IDLE, o_write=0, no o_cfg_ack ever; config outputs unchanged; rr restarts at requester 0.
